seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 35 +++
 rtl/hex_seg_decoder.sv | 11 +
 rtl/seg_scan_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking gap and frame-synchronous updates.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned GAP      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*N_DIGITS-1:0] wr_data,
  output logic [6:0]            seg_n,
  output logic [N_DIGITS-1:0]   dig_n,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DW    = 4 * N_DIGITS;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [DW-1:0]       disp;
  logic [DW-1:0]       shadow;
  logic                pending;

  logic                slot_end_c;
  logic                frame_end_c;
  logic                commit_c;
  logic                blank_c;
  logic [3:0]          nib_c;
  logic [6:0]          seg_c;
  logic [N_DIGITS-1:0] sel_c;

  assign slot_end_c  = (state == SHOW) && (cnt == CNT_W'(DIV - 1));
  assign frame_end_c = slot_end_c && (idx == IDX_W'(N_DIGITS - 1)) && en;
  // Shadow only reaches disp between frames, so a frame never tears
  assign commit_c    = pending && (frame_end_c || (state == OFF));
  assign wr_ready    = ~pending;

  always_comb begin
    nib_c = 4'h0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) nib_c = disp[4*i +: 4];
    end
  end

  assign sel_c = ~(N_DIGITS'(1) << idx);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_c;
  logic                zero_run;

  // A digit is dark while it and every digit to its left are zero; digit 0 always shows
  always_comb begin
    lz_c     = '0;
    zero_run = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      zero_run = zero_run && (disp[4*i +: 4] == 4'h0);
      lz_c[i]  = zero_run;
    end
  end

  assign blank_c = lz_c[idx];
`else
  assign blank_c = 1'b0;
`endif

  hex_seg_decoder u_dec (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      seg_n      <= SEG_OFF;
      dig_n      <= '1;
    end else begin
      frame_done <= frame_end_c;
      if ((state == SHOW) && !blank_c) begin
        seg_n <= seg_c;
        dig_n <= sel_c;
      end else begin
        seg_n <= SEG_OFF;
        dig_n <= '1;
      end
      if (!en) begin
        state <= OFF;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          OFF: begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(GAP - 1)) state <= SHOW;
          end
          SHOW: begin
            if (slot_end_c) begin
              state <= BLANK;
              cnt   <= '0;
              idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

  // Write-side shadow register and commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (commit_c) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (wr_valid && !pending) begin
      shadow  <= wr_data;
      pending <= 1'b1;
    end
  end

endmodule
